i2c_master_byte_ctrl: RTL and testbench

//  Byte-level I2C master engine; sits directly upstream of the I2C bus interface.

---
 rtl/i2c_master_byte_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_i2c_master_byte_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_byte_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_master_byte_ctrl
// Byte-level I2C master engine. Converts START / WRITE / READ / STOP commands
// into open-drain SCL/SDA drive levels and samples the resolved bus for ACK,
// read data, arbitration loss and (optionally) clock stretching.
//
// Parameters
//   QTR_DIV  clk cycles per SCL quarter-period (>= 2)
//   DIV_W    width of the quarter-period counter (must hold QTR_DIV-1)
//
// Configuration macro
//   I2C_CLK_STRETCH_EN  when defined, every quarter Q1 (SCL released) is held
//                       at its last cycle until the synchronised SCL reads 1.
//                       When undefined, timing is fixed and scl_in is unused.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_op 00 START, 01 WRITE,
//                       10 READ, 11 STOP; cmd_wdata byte to send;
//                       cmd_ack_out ACK level sent after a READ
//   rsp_valid           one-cycle completion pulse with rsp_rdata (READ byte),
//                       rsp_ack (slave ACK after WRITE), rsp_arb_lost
//   busy                1 between START completion and STOP / arbitration loss
//   scl_in, sda_in      resolved bus levels
//   scl_drive, sda_drive  1 = release line, 0 = pull low
// -----------------------------------------------------------------------------
module i2c_master_byte_ctrl #(
  parameter int QTR_DIV = 250,
  parameter int DIV_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_ack_out,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_ack,
  output logic       rsp_arb_lost,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_drive,
  output logic       sda_drive
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [DIV_W-1:0] QTR_LAST = DIV_W'(QTR_DIV - 1);
  localparam logic [DIV_W-1:0] QCNT_ONE = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BIT   = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // SDA level the master intends for bit idx of a byte transfer
  function automatic logic bit_level(input logic [1:0] op, input logic [3:0] idx,
                                     input logic [7:0] wd, input logic ack);
    logic lvl;
    lvl = 1'b1;
    case (op)
      OP_WRITE: begin
        if (idx < 4'd8) lvl = wd[3'd7 - idx[2:0]];
        else            lvl = 1'b1;
      end
      OP_READ: begin
        if (idx < 4'd8) lvl = 1'b1;
        else            lvl = ack;
      end
      default: lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // registers
  state_t           state_r;
  logic [1:0]       qtr_r;
  logic [DIV_W-1:0] qcnt_r;
  logic [3:0]       bit_r;
  logic [1:0]       op_r;
  logic [7:0]       wdata_r;
  logic             ack_out_r;
  logic [7:0]       rx_r;
  logic             scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
  logic             cmd_ready_r, rsp_valid_r, rsp_ack_r, rsp_arb_lost_r, busy_r;
  logic [7:0]       rsp_rdata_r;
  logic             scl_drive_r, sda_drive_r;

  // combinational signals
  state_t           state_nxt_s;
  logic [1:0]       qtr_nxt_s;
  logic [DIV_W-1:0] qcnt_nxt_s;
  logic [3:0]       bit_nxt_s;
  logic             accept_s, last_cyc_s, stretch_s, qtr_end_s;
  logic             check_s, cur_lvl_s, arb_s, samp_s, done_s;
  logic [1:0]       op_s;
  logic [7:0]       wdata_s;
  logic             ack_out_s, nxt_lvl_s;
  logic             scl_nxt_s, sda_nxt_s, busy_nxt_s, rsp_ack_nxt_s;
  logic [7:0]       rsp_rdata_nxt_s, rx_nxt_s;

  assign accept_s   = cmd_valid & cmd_ready_r;
  assign last_cyc_s = (qcnt_r == QTR_LAST);

`ifdef I2C_CLK_STRETCH_EN
  assign stretch_s = (state_r != ST_IDLE) && (qtr_r == 2'd1) && !scl_sync_r;
`else
  logic unused_scl_s;
  assign stretch_s    = 1'b0;
  assign unused_scl_s = scl_sync_r;
`endif

  assign qtr_end_s = last_cyc_s & ~stretch_s;

  // Only bits the master actually drives as data take part in arbitration:
  // WRITE data bits and the READ acknowledge bit.
  assign check_s   = ((op_r == OP_WRITE) && (bit_r < 4'd8)) ||
                     ((op_r == OP_READ)  && (bit_r == 4'd8));
  assign cur_lvl_s = bit_level(op_r, bit_r, wdata_r, ack_out_r);
  assign arb_s     = (state_r == ST_BIT) && (qtr_r == 2'd2) && check_s &&
                     cur_lvl_s && !sda_sync_r;
  assign samp_s    = (state_r == ST_BIT) && (qtr_r == 2'd2) && last_cyc_s && !arb_s;
  assign done_s    = (state_r != ST_IDLE) && (state_nxt_s == ST_IDLE);

  // Command fields as they will be seen by the next cycle (bypass on accept)
  assign op_s      = accept_s ? cmd_op      : op_r;
  assign wdata_s   = accept_s ? cmd_wdata   : wdata_r;
  assign ack_out_s = accept_s ? cmd_ack_out : ack_out_r;
  assign nxt_lvl_s = bit_level(op_s, bit_nxt_s, wdata_s, ack_out_s);

  // State register: FSM, counters, command capture and input synchronisers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      qtr_r      <= 2'd0;
      qcnt_r     <= '0;
      bit_r      <= 4'd0;
      op_r       <= OP_START;
      wdata_r    <= 8'h00;
      ack_out_r  <= 1'b1;
      rx_r       <= 8'h00;
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      qtr_r      <= qtr_nxt_s;
      qcnt_r     <= qcnt_nxt_s;
      bit_r      <= bit_nxt_s;
      rx_r       <= rx_nxt_s;
      scl_meta_r <= scl_in;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= sda_in;
      sda_sync_r <= sda_meta_r;
      if (accept_s) begin
        op_r      <= cmd_op;
        wdata_r   <= cmd_wdata;
        ack_out_r <= cmd_ack_out;
      end
    end
  end

  // Next-state logic: quarter/bit sequencing, arbitration abort
  always_comb begin
    state_nxt_s = state_r;
    qtr_nxt_s   = qtr_r;
    qcnt_nxt_s  = qcnt_r;
    bit_nxt_s   = bit_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_START: state_nxt_s = ST_START;
            OP_STOP:  state_nxt_s = ST_STOP;
            default:  state_nxt_s = ST_BIT;
          endcase
          qtr_nxt_s  = 2'd0;
          qcnt_nxt_s = '0;
          bit_nxt_s  = 4'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        if (arb_s) begin
          state_nxt_s = ST_IDLE;
          qtr_nxt_s   = 2'd0;
          qcnt_nxt_s  = '0;
          bit_nxt_s   = 4'd0;
        end else if (qtr_end_s) begin
          qcnt_nxt_s = '0;
          if (qtr_r == 2'd3) begin
            qtr_nxt_s = 2'd0;
            if ((state_r == ST_BIT) && (bit_r != 4'd8)) begin
              bit_nxt_s = bit_r + 4'd1;
            end else begin
              state_nxt_s = ST_IDLE;
              bit_nxt_s   = 4'd0;
            end
          end else begin
            qtr_nxt_s = qtr_r + 2'd1;
          end
        end else if (last_cyc_s) begin
          // SCL stretched by a slave: hold on the last cycle of Q1
          qcnt_nxt_s = qcnt_r;
        end else begin
          qcnt_nxt_s = qcnt_r + QCNT_ONE;
        end
      end
    endcase
  end

  // Output logic: line levels for the upcoming quarter and response fields
  always_comb begin
    scl_nxt_s = scl_drive_r;
    sda_nxt_s = sda_drive_r;
    case (state_nxt_s)
      ST_START: begin
        case (qtr_nxt_s)
          2'd0:    begin scl_nxt_s = scl_drive_r; sda_nxt_s = 1'b1; end
          2'd1:    begin scl_nxt_s = 1'b1;        sda_nxt_s = 1'b1; end
          2'd2:    begin scl_nxt_s = 1'b1;        sda_nxt_s = 1'b0; end
          default: begin scl_nxt_s = 1'b0;        sda_nxt_s = 1'b0; end
        endcase
      end
      ST_BIT: begin
        scl_nxt_s = (qtr_nxt_s == 2'd1) || (qtr_nxt_s == 2'd2);
        sda_nxt_s = nxt_lvl_s;
      end
      ST_STOP: begin
        case (qtr_nxt_s)
          2'd0:    begin scl_nxt_s = scl_drive_r; sda_nxt_s = 1'b0; end
          2'd1:    begin scl_nxt_s = 1'b1;        sda_nxt_s = 1'b0; end
          default: begin scl_nxt_s = 1'b1;        sda_nxt_s = 1'b1; end
        endcase
      end
      default: begin
        // IDLE keeps the bus where the last command left it, unless we lost it
        if (arb_s) begin
          scl_nxt_s = 1'b1;
          sda_nxt_s = 1'b1;
        end else begin
          scl_nxt_s = scl_drive_r;
          sda_nxt_s = sda_drive_r;
        end
      end
    endcase

    if (done_s && (state_r == ST_START)) begin
      busy_nxt_s = 1'b1;
    end else if (done_s && ((state_r == ST_STOP) || arb_s)) begin
      busy_nxt_s = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end

    if (samp_s && (op_r == OP_READ) && (bit_r < 4'd8)) begin
      rx_nxt_s = {rx_r[6:0], sda_sync_r};
    end else begin
      rx_nxt_s = rx_r;
    end

    if (samp_s && (op_r == OP_WRITE) && (bit_r == 4'd8)) begin
      rsp_ack_nxt_s = sda_sync_r;
    end else begin
      rsp_ack_nxt_s = rsp_ack_r;
    end

    if (done_s && (op_r == OP_READ) && !arb_s) begin
      rsp_rdata_nxt_s = rx_r;
    end else begin
      rsp_rdata_nxt_s = rsp_rdata_r;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_drive_r    <= 1'b1;
      sda_drive_r    <= 1'b1;
      cmd_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      rsp_rdata_r    <= 8'h00;
      rsp_ack_r      <= 1'b1;
      rsp_arb_lost_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      scl_drive_r    <= scl_nxt_s;
      sda_drive_r    <= sda_nxt_s;
      cmd_ready_r    <= (state_nxt_s == ST_IDLE);
      rsp_valid_r    <= done_s;
      rsp_rdata_r    <= rsp_rdata_nxt_s;
      rsp_ack_r      <= rsp_ack_nxt_s;
      rsp_arb_lost_r <= arb_s;
      busy_r         <= busy_nxt_s;
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign rsp_ack      = rsp_ack_r;
  assign rsp_arb_lost = rsp_arb_lost_r;
  assign busy         = busy_r;
  assign scl_drive    = scl_drive_r;
  assign sda_drive    = sda_drive_r;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Self-checking bench for i2c_master_byte_ctrl (QTR_DIV = 4).
// Commands push expected responses into a queue; a monitor pops and compares
// on every rsp_valid pulse. A simple slave model pulls SCL/SDA through
// wired-AND bus levels.
module tb_i2c_master_byte_ctrl;

  localparam int QD = 4;
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_LAT = 165;
`else
  localparam int STRETCH_LAT = 145;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ack_out = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_ack;
  logic       rsp_arb_lost;
  logic       busy;
  logic       scl_in, sda_in, scl_drive, sda_drive;
  logic       slave_scl = 1'b1;
  logic       slave_sda = 1'b1;

  assign scl_in = scl_drive & slave_scl;
  assign sda_in = sda_drive & slave_sda;

  i2c_master_byte_ctrl #(.QTR_DIV(QD), .DIV_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .cmd_ack_out(cmd_ack_out),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack),
    .rsp_arb_lost(rsp_arb_lost), .busy(busy),
    .scl_in(scl_in), .sda_in(sda_in), .scl_drive(scl_drive), .sda_drive(sda_drive)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cyc  = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] rdata;
    logic       ack;
    logic       arb;
    int         acc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

  function automatic void check(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: every completion pulse is matched against the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_arb_lost", rsp_arb_lost, e.arb);
        if (e.op == OP_WRITE && !e.arb) check("rsp_ack", rsp_ack, e.ack);
        if (e.op == OP_READ && !e.arb) check("rsp_rdata", rsp_rdata, e.rdata);
        if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Issue one command from a negedge; returns at the negedge after acceptance
  task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic ao,
                       input logic [7:0] er, input logic ea, input logic earb,
                       input int lat);
    int   n = 0;
    exp_t e;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", cmd_ready, 1);
    end else begin
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_wdata   = wd;
      cmd_ack_out = ao;
      acc_cyc     = cyc;
      e.op = op; e.rdata = er; e.ack = ea; e.arb = earb; e.acc = cyc; e.lat = lat;
      exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rel(input int r);
    while (cyc < acc_cyc + r) @(negedge clk);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", rsp_valid, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [7:0] pat;
    // 1. reset values
    repeat (3) @(negedge clk);
    check("rst_scl_drive", scl_drive, 1);
    check("rst_sda_drive", sda_drive, 1);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_ack", rsp_ack, 1);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // 2. START, WRITE 0xA5 with slave ACK, STOP
    issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    check("start_busy", busy, 1);
    pat = 8'hA5;
    issue(OP_WRITE, pat, 1'b0, 8'h00, 1'b0, 1'b0, 36*QD+1);
    for (int b = 0; b < 8; b++) begin
      wait_rel(16*b + 2);
      check("write_q0_sda", sda_drive, pat[7-b]);
    end
    wait_rel(129);
    slave_sda = 1'b0;
    wait_rsp();
    slave_sda = 1'b1;
    issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    check("stop_busy", busy, 0);
    check("stop_scl", scl_drive, 1);
    check("stop_sda", sda_drive, 1);

    // 3. START, READ 0x3C with NACK, STOP
    issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    pat = 8'h3C;
    issue(OP_READ, 8'h00, 1'b1, pat, 1'b1, 1'b0, 36*QD+1);
    for (int b = 0; b < 8; b++) begin
      wait_rel(16*b + 1);
      slave_sda = pat[7-b];
      wait_rel(16*b + 10);
      check("read_sda_released", sda_drive, 1);
    end
    wait_rel(129);
    slave_sda = 1'b1;
    wait_rel(138);
    check("read_nack_sda", sda_drive, 1);
    wait_rsp();
    issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();

    // 4. START, WRITE 0xFF, SDA forced low during bit 2 -> arbitration lost
    issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    issue(OP_WRITE, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 42);
    wait_rel(33);
    slave_sda = 1'b0;
    wait_rsp();
    check("arb_scl", scl_drive, 1);
    check("arb_sda", sda_drive, 1);
    check("arb_busy", busy, 0);
    check("arb_cmd_ready", cmd_ready, 1);
    slave_sda = 1'b1;
    repeat (4) @(negedge clk);

    // 5. clock stretching in bit 0 of a WRITE, no slave ACK
    issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    issue(OP_WRITE, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, STRETCH_LAT);
    wait_rel(4);
    slave_scl = 1'b0;
    wait_rel(26);
    slave_scl = 1'b1;
    wait_rsp();
    issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();

    // 6. reset in the middle of a READ (bit 4)
    issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    issue(OP_READ, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, -1);
    wait_rel(70);
    check("mid_read_busy", busy, 1);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("abort_scl", scl_drive, 1);
    check("abort_sda", sda_drive, 1);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    repeat (60) @(negedge clk);

    // recovery after the abort
    issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 4*QD+1);
    wait_rsp();
    repeat (4) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
